// File: rtl/store_pkg.sv
// Shared store-path definitions: funct3 encodings, FSM states, error codes,
// and the latched memory command.
package store_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_REQ      = 2'b01,
    S_WAIT_ACK = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_ILLEGAL  = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } err_code_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_cmd_t;

endpackage

// File: rtl/store_align.sv
// Combinational store formatting: lane-replicated data, byte enables and
// fault detection from the low address bits and funct3.
module store_align
  import store_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  input  logic [31:0] data,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        misalign,
  output logic        illegal
);

  // Decode size; misalignment is only meaningful for a legal funct3.
  always_comb begin
    wdata    = data;
    be       = 4'b0000;
    misalign = 1'b0;
    illegal  = 1'b0;
    case (funct3)
      F3_SB: begin
        wdata = {4{data[7:0]}};
        be    = 4'(4'b0001 << addr);
      end
      F3_SH: begin
        wdata    = {2{data[15:0]}};
        be       = 4'(4'b0011 << addr);
        misalign = addr[0];
      end
      F3_SW: begin
        wdata    = data;
        be       = 4'b1111;
        misalign = (addr != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// RV32I store unit: accepts one store, formats it, and drives the
// req/gnt/ack data-memory handshake with a timeout abort.
module store_unit
  import store_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        st_valid_i,
  output logic        st_ready_o,
  input  logic [31:0] st_addr_i,
  input  logic [31:0] st_data_i,
  input  logic [2:0]  st_funct3_i,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  input  logic        mem_ack_i,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  output logic        st_done_o,
  output logic        st_err_o,
  output logic [1:0]  st_err_code_o
);

  state_t           state, state_n;
  mem_cmd_t         cmd_q;
  err_code_t        err_code_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ready_q, done_q, err_q;
  logic [31:0]      al_wdata;
  logic [3:0]       al_be;
  logic             al_misalign, al_illegal;
  logic             accept, fault, cnt_hit, fin_ok, fin_to;

  store_align u_align (
    .addr     (st_addr_i[1:0]),
    .funct3   (st_funct3_i),
    .data     (st_data_i),
    .wdata    (al_wdata),
    .be       (al_be),
    .misalign (al_misalign),
    .illegal  (al_illegal)
  );

  assign accept  = st_valid_i & ready_q;
  assign fault   = al_misalign | al_illegal;
  assign cnt_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= S_IDLE;
    else         state <= state_n;
  end

  // Next state; an ack arriving on the timeout cycle still completes the store.
  always_comb begin
    state_n = state;
    fin_ok  = 1'b0;
    fin_to  = 1'b0;
    case (state)
      S_IDLE: if (accept && !fault) state_n = S_REQ;
      S_REQ: begin
        if (mem_gnt_i && mem_ack_i) begin
          state_n = S_IDLE;
          fin_ok  = 1'b1;
        end else if (cnt_hit) begin
          state_n = S_IDLE;
          fin_to  = 1'b1;
        end else if (mem_gnt_i) begin
          state_n = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (mem_ack_i) begin
          state_n = S_IDLE;
          fin_ok  = 1'b1;
        end else if (cnt_hit) begin
          state_n = S_IDLE;
          fin_to  = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs: request is a pure state decode, everything else is registered.
  always_comb begin
    mem_req_o     = (state == S_REQ);
    st_ready_o    = ready_q;
    st_done_o     = done_q;
    st_err_o      = err_q;
    st_err_code_o = err_code_q;
    mem_addr_o    = cmd_q.addr;
    mem_wdata_o   = cmd_q.wdata;
    mem_be_o      = cmd_q.be;
  end

  // Handshake flags, latched command and the REQ/WAIT_ACK timeout counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      cmd_q      <= '0;
      cnt_q      <= '0;
    end else begin
      ready_q <= (state_n == S_IDLE);
      done_q  <= fin_ok;
      err_q   <= (accept && fault) || fin_to;
      if (accept && fault)
        err_code_q <= al_illegal ? ERR_ILLEGAL : ERR_MISALIGN;
      else if (fin_to)
        err_code_q <= ERR_TIMEOUT;
      if (accept && !fault)
        cmd_q <= '{addr: {st_addr_i[31:2], 2'b00}, wdata: al_wdata, be: al_be};
      cnt_q <= (state == S_IDLE) ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit with a short timeout (4 cycles).
module tb_store_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        st_valid_i;
  logic        st_ready_o;
  logic [31:0] st_addr_i;
  logic [31:0] st_data_i;
  logic [2:0]  st_funct3_i;
  logic        mem_req_o;
  logic        mem_gnt_i;
  logic        mem_ack_i;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        st_done_o;
  logic        st_err_o;
  logic [1:0]  st_err_code_o;

  int n_chk = 0;
  int n_bad = 0;

  store_unit #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .st_valid_i    (st_valid_i),
    .st_ready_o    (st_ready_o),
    .st_addr_i     (st_addr_i),
    .st_data_i     (st_data_i),
    .st_funct3_i   (st_funct3_i),
    .mem_req_o     (mem_req_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_ack_i     (mem_ack_i),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_be_o      (mem_be_o),
    .st_done_o     (st_done_o),
    .st_err_o      (st_err_o),
    .st_err_code_o (st_err_code_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    st_valid_i  = 1'b1;
    st_addr_i   = a;
    st_data_i   = d;
    st_funct3_i = f3;
    step();
    st_valid_i  = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; st_valid_i = 1'b0; st_addr_i = '0; st_data_i = '0;
    st_funct3_i = 3'b000; mem_gnt_i = 1'b0; mem_ack_i = 1'b0;
    #3;
    chk("rst_ready", st_ready_o, 0);
    chk("rst_req",   mem_req_o,  0);
    chk("rst_done",  st_done_o,  0);
    chk("rst_err",   st_err_o,   0);
    chk("rst_addr",  mem_addr_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    chk("rst_be",    mem_be_o,   0);
    chk("rst_code",  st_err_code_o, 0);
    step(); step();
    rst_ni = 1'b1;
    #1 chk("ready_before_edge", st_ready_o, 0);
    step();
    chk("ready_after_edge", st_ready_o, 1);

    // SB to byte 3, separate gnt and ack
    issue(32'h1003, 32'h0000_00AB, 3'b000);
    chk("sb_req",   mem_req_o,   1);
    chk("sb_ready", st_ready_o,  0);
    chk("sb_addr",  mem_addr_o,  32'h1000);
    chk("sb_be",    mem_be_o,    4'b1000);
    chk("sb_wdata", mem_wdata_o, 32'hABAB_ABAB);
    mem_gnt_i = 1'b1; step(); mem_gnt_i = 1'b0;
    chk("sb_wait_req", mem_req_o, 0);
    chk("sb_wait_done", st_done_o, 0);
    mem_ack_i = 1'b1; step(); mem_ack_i = 1'b0;
    chk("sb_done",  st_done_o,  1);
    chk("sb_err",   st_err_o,   0);
    chk("sb_ready2", st_ready_o, 1);
    step();
    chk("sb_done_pulse", st_done_o, 0);

    // SH upper half, gnt+ack together
    issue(32'h2002, 32'h0000_1234, 3'b001);
    chk("sh_req",   mem_req_o,   1);
    chk("sh_be",    mem_be_o,    4'b1100);
    chk("sh_wdata", mem_wdata_o, 32'h1234_1234);
    chk("sh_addr",  mem_addr_o,  32'h2000);
    mem_gnt_i = 1'b1; mem_ack_i = 1'b1; step(); mem_gnt_i = 1'b0; mem_ack_i = 1'b0;
    chk("sh_done",  st_done_o,  1);
    chk("sh_ready", st_ready_o, 1);
    chk("sh_req_lo", mem_req_o, 0);
    step();

    // SH misaligned
    issue(32'h2001, 32'h0000_5555, 3'b001);
    chk("shm_err",   st_err_o,      1);
    chk("shm_code",  st_err_code_o, 2'b01);
    chk("shm_req",   mem_req_o,     0);
    chk("shm_ready", st_ready_o,    1);
    chk("shm_done",  st_done_o,     0);
    step();
    chk("shm_err_pulse", st_err_o, 0);

    // SW aligned, gnt&ack on first request cycle
    issue(32'h3000, 32'hDEAD_BEEF, 3'b010);
    chk("sw_req",   mem_req_o,   1);
    chk("sw_be",    mem_be_o,    4'b1111);
    chk("sw_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    mem_gnt_i = 1'b1; mem_ack_i = 1'b1; step(); mem_gnt_i = 1'b0; mem_ack_i = 1'b0;
    chk("sw_done",  st_done_o,  1);
    chk("sw_ready", st_ready_o, 1);
    step();

    // Illegal funct3 outranks misalignment
    issue(32'h3001, 32'h0000_0001, 3'b011);
    chk("ill_err",  st_err_o,      1);
    chk("ill_code", st_err_code_o, 2'b10);
    chk("ill_req",  mem_req_o,     0);
    step();

    // SW misaligned
    issue(32'h3002, 32'h0000_0001, 3'b010);
    chk("swm_code", st_err_code_o, 2'b01);
    chk("swm_err",  st_err_o,      1);
    step();

    // SB byte 1: ack without gnt in REQ is ignored
    issue(32'h5001, 32'h0000_005A, 3'b000);
    mem_ack_i = 1'b1; step(); mem_ack_i = 1'b0;
    chk("ign_req",  mem_req_o,   1);
    chk("ign_done", st_done_o,   0);
    chk("ign_be",   mem_be_o,    4'b0010);
    chk("ign_wdata", mem_wdata_o, 32'h5A5A_5A5A);
    mem_gnt_i = 1'b1; step(); mem_gnt_i = 1'b0;
    mem_ack_i = 1'b1; step(); mem_ack_i = 1'b0;
    chk("ign_fin_done", st_done_o, 1);
    step();

    // Timeout: gnt, never ack -> code 11 four edges after REQ entry
    issue(32'h4000, 32'h0000_0001, 3'b010);
    mem_gnt_i = 1'b1; step(); mem_gnt_i = 1'b0;
    chk("to_wait_err1", st_err_o, 0);
    step(); chk("to_wait_err2", st_err_o, 0);
    step(); chk("to_wait_err3", st_err_o, 0);
    step();
    chk("to_err",   st_err_o,      1);
    chk("to_code",  st_err_code_o, 2'b11);
    chk("to_req",   mem_req_o,     0);
    chk("to_done",  st_done_o,     0);
    chk("to_ready", st_ready_o,    1);
    step();
    chk("to_err_pulse", st_err_o, 0);

    // Ack on the timeout cycle completes normally
    issue(32'h6000, 32'h0000_0002, 3'b010);
    mem_gnt_i = 1'b1; step(); mem_gnt_i = 1'b0;
    step(); step();
    mem_ack_i = 1'b1; step(); mem_ack_i = 1'b0;
    chk("race_done", st_done_o, 1);
    chk("race_err",  st_err_o,  0);
    step();

    // Reset during WAIT_ACK
    issue(32'h7000, 32'h1111_2222, 3'b010);
    mem_gnt_i = 1'b1; step(); mem_gnt_i = 1'b0;
    chk("mid_wait_req", mem_req_o, 0);
    rst_ni = 1'b0;
    #1;
    chk("mid_ready", st_ready_o, 0);
    chk("mid_addr",  mem_addr_o, 0);
    chk("mid_wdata", mem_wdata_o, 0);
    chk("mid_be",    mem_be_o, 0);
    chk("mid_done",  st_done_o, 0);
    chk("mid_err",   st_err_o, 0);
    mem_ack_i = 1'b1;
    step(); step();
    mem_ack_i = 1'b0;
    rst_ni = 1'b1;
    #1 chk("mid_ready_rel", st_ready_o, 0);
    step();
    chk("mid_ready_edge", st_ready_o, 1);
    chk("mid_no_done", st_done_o, 0);
    chk("mid_no_err",  st_err_o, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
